macc_array_ctrl: RTL
====================

Name: macc_array_ctrl

Overview:
- Sequencer for a ROWS x COLS systolic array of weight-stationary MACC PEs.
- Per command: optionally shifts a new weight tile row-by-row into the PE preweight registers, swaps it into the active weights, streams N input vectors with backpressure, then drains the MAC pipeline and skew.
- Sits between the weight/input buffers and the PE array; it generates only control strobes, and the data buses bypass it.

Parameters:
- ROWS, 4, array rows; one preload beat per row.
- COLS, 4, array columns; used only in the DRAIN_CYCLES default.
- CNT_W, 8, width of the vector-count field.
- DRAIN_CYCLES, ROWS+COLS+1, enable cycles with bubble input after the last vector. Covers the 3-stage PE pipeline plus row/column skew. Must be >= 1.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high
- cmd_new_weights  in  1  1 = preload and swap weights before compute
- cmd_num_vectors  in  CNT_W  input vectors to stream; 0 = weight update only
- wt_valid  in  1  weight row available on external bus
- wt_ready  out  1  controller consumes weight row
- preload_weight  out  ROWS  one-hot per-row preload strobe to PEs
- load_weight  out  1  preweight-to-weight swap strobe, broadcast
- in_valid  in  1  input vector available
- in_ready  out  1  controller consumes input vector
- enable  out  1  array advance strobe
- bubble  out  1  array input mux selects zero
- busy  out  1  not IDLE
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset is synchronous and active-high on clk. Reset forces IDLE, clears all counters and latched fields, and drives every output to 0 except cmd_ready. cmd_ready is 1 the cycle after reset is released.
- Reset mid-operation aborts immediately with no done pulse. The array contents are not the controller's concern.
- States and actions:
  - IDLE: cmd_ready=1. On a cmd handshake, latch both command fields.
    - new_weights=1 -> PRELOAD.
    - else num_vectors>0 -> STREAM.
    - else -> DONE.
  - PRELOAD: wt_ready=1. Each wt_valid&wt_ready beat pulses preload_weight[row_cnt] in the same cycle; row_cnt counts 0..ROWS-1. With wt_valid low, nothing is strobed and the state holds. On the beat with row_cnt=ROWS-1 -> SWAP.
  - SWAP: load_weight=1 for exactly one cycle, with no other strobe. Then num_vectors>0 -> STREAM, else DONE.
  - STREAM: in_ready=1 and enable=in_valid, so the array freezes while the source stalls. Each handshake increments vec_cnt. On the handshake where vec_cnt=num_vectors-1 -> DRAIN.
  - DRAIN: enable=1, bubble=1, in_ready=0 for exactly DRAIN_CYCLES cycles, then DONE.
  - DONE: done=1 for one cycle, then IDLE. cmd_ready=0 in DONE.
- busy=1 in every state except IDLE.
- preload_weight, load_weight and enable are mutually exclusive in time. Weights never change while enable is high.
- The weight row fed to the PEs on a strobe cycle is the one on the external bus in that same cycle; there is zero latency from handshake to strobe.
- Command latency with no stalls is 1 + (new_weights ? ROWS+1 : 0) + N + DRAIN_CYCLES + 1 cycles from cmd handshake to done, inclusive of the DONE cycle.
- Handshake signals are ignored in states where the corresponding ready is 0. No ready depends combinationally on its own valid.
- Boundary cases:
  - num_vectors = 2^CNT_W-1 must not overflow vec_cnt.
  - A back-to-back command is accepted in the IDLE cycle immediately after DONE.
  - A new cmd_valid during busy is held off by cmd_ready=0.

Test Plan (ROWS=4, COLS=4, DRAIN_CYCLES=9):
1. Reset released, idle inputs -> cmd_ready=1; all strobes, busy and done at 0.
2. cmd {new_weights=1, num=3}, wt_valid and in_valid held high -> preload_weight = 0001, 0010, 0100, 1000 on cycles 1-4 after accept; load_weight on cycle 5; enable without bubble on cycles 6-8; enable with bubble on cycles 9-17; done on cycle 18.
3. Same command with wt_valid low on the second beat and in_valid low for 2 cycles mid-stream -> no strobe during the stalls, row/vector order preserved, done delayed by exactly 3 cycles.
4. cmd {new_weights=0, num=0} -> done on the cycle after accept; no preload, load or enable strobes.
5. cmd {new_weights=1, num=0} -> 4 preload beats then load_weight, then done; enable never asserted.
6. Reset asserted during DRAIN -> next cycle IDLE, cmd_ready=1, no done pulse; a following command runs with correct counts.

Source files
------------

// File: rtl/macc_array_ctrl_if.sv
// Control-plane bundle between the MACC array sequencer and its buffers/PE array.
// Only handshakes and strobes live here; weight and input data buses bypass the controller.
interface macc_array_ctrl_if #(
  parameter int ROWS  = 4,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_new_weights;
  logic [CNT_W-1:0] cmd_num_vectors;
  logic             wt_valid;
  logic             wt_ready;
  logic [ROWS-1:0]  preload_weight;
  logic             load_weight;
  logic             in_valid;
  logic             in_ready;
  logic             enable;
  logic             bubble;
  logic             busy;
  logic             done;

  // master: command/weight/input sources plus the array that consumes strobes
  modport master (
    output cmd_valid, cmd_new_weights, cmd_num_vectors, wt_valid, in_valid,
    input  cmd_ready, wt_ready, preload_weight, load_weight, in_ready,
           enable, bubble, busy, done
  );

  // slave: the sequencer itself
  modport slave (
    input  cmd_valid, cmd_new_weights, cmd_num_vectors, wt_valid, in_valid,
    output cmd_ready, wt_ready, preload_weight, load_weight, in_ready,
           enable, bubble, busy, done
  );
endinterface

// File: rtl/macc_array_ctrl.sv
// Weight-stationary systolic array sequencer: preload rows, swap, stream N vectors, drain, pulse done.
// Latency 1+(new_weights?ROWS+1:0)+N+DRAIN_CYCLES+1 cycles; wt/in stalls freeze the array, cmd held off while busy.
module macc_array_ctrl #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int CNT_W        = 8,
  parameter int DRAIN_CYCLES = ROWS + COLS + 1
) (
  input logic              clk,
  input logic              reset,
  macc_array_ctrl_if.slave bus
);

  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRELOAD = 3'd1,
    S_SWAP    = 3'd2,
    S_STREAM  = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ROW_W-1:0]   row_cnt;
  logic [CNT_W-1:0]   vec_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [CNT_W-1:0]   num_vectors_q;

  logic cmd_hs;
  logic wt_hs;
  logic in_hs;
  logic last_row;
  logic last_vec;
  logic last_drain;

  // Handshakes decode from state, not from the ready outputs, so no ready sees its own valid.
  assign cmd_hs     = (state == S_IDLE)    && bus.cmd_valid;
  assign wt_hs      = (state == S_PRELOAD) && bus.wt_valid;
  assign in_hs      = (state == S_STREAM)  && bus.in_valid;
  assign last_row   = (row_cnt == ROW_W'(ROWS - 1));
  assign last_vec   = (vec_cnt == num_vectors_q - 1'b1);
  assign last_drain = (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_new_weights) begin
            state_nxt = S_PRELOAD;
          end else if (bus.cmd_num_vectors != '0) begin
            state_nxt = S_STREAM;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_PRELOAD: begin
        if (bus.wt_valid && last_row) begin
          state_nxt = S_SWAP;
        end
      end
      S_SWAP: begin
        state_nxt = (num_vectors_q != '0) ? S_STREAM : S_DONE;
      end
      S_STREAM: begin
        if (bus.in_valid && last_vec) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_drain) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    bus.cmd_ready      = 1'b0;
    bus.wt_ready       = 1'b0;
    bus.in_ready       = 1'b0;
    bus.preload_weight = '0;
    bus.load_weight    = 1'b0;
    bus.enable         = 1'b0;
    bus.bubble         = 1'b0;
    bus.done           = 1'b0;
    bus.busy           = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
      end
      S_PRELOAD: begin
        bus.wt_ready = 1'b1;
        // Zero-latency strobe: the row on the external bus this cycle lands in PE row row_cnt.
        for (int r = 0; r < ROWS; r++) begin
          bus.preload_weight[r] = bus.wt_valid && (row_cnt == ROW_W'(r));
        end
      end
      S_SWAP: begin
        bus.load_weight = 1'b1;
      end
      S_STREAM: begin
        bus.in_ready = 1'b1;
        bus.enable   = bus.in_valid;
      end
      S_DRAIN: begin
        bus.enable = 1'b1;
        bus.bubble = 1'b1;
      end
      S_DONE: begin
        bus.done = 1'b1;
      end
      default: begin
        bus.busy = 1'b1;
      end
    endcase
  end

  // Counters wrap to zero on their last step, so every command starts from a clean slate.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_cnt       <= '0;
      vec_cnt       <= '0;
      drain_cnt     <= '0;
      num_vectors_q <= '0;
    end else begin
      if (cmd_hs) begin
        num_vectors_q <= bus.cmd_num_vectors;
        row_cnt       <= '0;
        vec_cnt       <= '0;
        drain_cnt     <= '0;
      end
      if (wt_hs) begin
        row_cnt <= last_row ? '0 : row_cnt + 1'b1;
      end
      if (in_hs) begin
        vec_cnt <= last_vec ? '0 : vec_cnt + 1'b1;
      end
      if (state == S_DRAIN) begin
        drain_cnt <= last_drain ? '0 : drain_cnt + 1'b1;
      end
    end
  end

endmodule
